// File: rtl/memory.sv
// Pipeline memory stage: issues loads/stores on a split addr/data bus and
// registers the writeback bundle, stalling execute while an access is pending.
package memory_pkg;
    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_NOP   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    typedef struct packed {
        op_t    op;
        msize_t msize;
        logic   mem_unsigned;
        logic   reg_write;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] rd2;
        logic [63:0] result;
    } excute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] result;
    } memory_data_t;
endpackage

module memory
    import memory_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    output memory_data_t dataM,
    output logic         stopm,
    output logic         dreq_valid,
    output logic [63:0]  dreq_addr,
    output logic [2:0]   dreq_size,
    output logic [7:0]   dreq_strobe,
    output logic [63:0]  dreq_data,
    input  logic         dresp_addr_ok,
    input  logic         dresp_data_ok,
    input  logic [63:0]  dresp_data
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ADDR = 2'd1,
        S_WAIT_DATA = 2'd2
    } state_t;

    state_t       state_q, state_d;
    excute_data_t h_q, h_d;
    memory_data_t data_m_q, data_m_d;

    excute_data_t req;
    logic         req_is_mem;
    logic         issue;
    logic         busy;
    logic         complete;
    logic [2:0]   off;
    logic [7:0]   size_mask;
    logic [63:0]  load_val;

    function automatic memory_data_t to_mem(input excute_data_t e, input logic [63:0] res);
        memory_data_t m;
        m.valid  = e.valid;
        m.pc     = e.pc;
        m.instr  = e.instr;
        m.ctl    = e.ctl;
        m.dst    = e.dst;
        m.result = res;
        return m;
    endfunction

    // Shift the addressed lanes down, truncate to the access size, then extend.
    function automatic logic [63:0] extract(input logic [63:0] raw, input logic [2:0] o,
                                            input msize_t sz, input logic uns);
        logic [63:0] s;
        logic        sgn;
        s = raw >> {o, 3'b000};
        case (sz)
            MSIZE_B: begin sgn = ~uns & s[7];  extract = {{56{sgn}}, s[7:0]};  end
            MSIZE_H: begin sgn = ~uns & s[15]; extract = {{48{sgn}}, s[15:0]}; end
            MSIZE_W: begin sgn = ~uns & s[31]; extract = {{32{sgn}}, s[31:0]}; end
            default: begin sgn = 1'b0;         extract = s;                    end
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        h_d      = h_q;
        data_m_d = '0;

        req        = (state_q == S_IDLE) ? dataE : h_q;
        req_is_mem = (req.ctl.op == OP_LOAD) || (req.ctl.op == OP_STORE);
        issue      = (state_q == S_IDLE) && dataE.valid && req_is_mem;
        busy       = issue || (state_q != S_IDLE);
        off        = req.result[2:0];

        case (state_q)
            S_IDLE:      complete = issue && dresp_addr_ok && dresp_data_ok;
            S_WAIT_ADDR: complete = dresp_addr_ok && dresp_data_ok;
            S_WAIT_DATA: complete = dresp_data_ok;
            default:     complete = 1'b0;
        endcase

        case (req.ctl.msize)
            MSIZE_B: size_mask = 8'h01;
            MSIZE_H: size_mask = 8'h03;
            MSIZE_W: size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase

        // Gated by reset so nothing is offered to the bus while the stage is being cleared.
        stopm       = reset && busy && !complete;
        dreq_valid  = reset && (issue || (state_q == S_WAIT_ADDR));
        dreq_addr   = req.result;
        dreq_size   = {1'b0, req.ctl.msize};
        dreq_strobe = (req.ctl.op == OP_STORE) ? (size_mask << off) : 8'h00;
        dreq_data   = req.rd2 << {off, 3'b000};
        load_val    = extract(dresp_data, off, req.ctl.msize, req.ctl.mem_unsigned);

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    h_d = dataE;
                    if (complete)           state_d = S_IDLE;
                    else if (dresp_addr_ok) state_d = S_WAIT_DATA;
                    else                    state_d = S_WAIT_ADDR;
                end
            end
            S_WAIT_ADDR: begin
                if (dresp_addr_ok) state_d = dresp_data_ok ? S_IDLE : S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (dresp_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            data_m_d       = to_mem(req, (req.ctl.op == OP_LOAD) ? load_val : req.result);
            data_m_d.valid = 1'b1;
        end else if (state_q == S_IDLE && !issue) begin
            data_m_d = to_mem(dataE, dataE.result);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (!reset) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            data_m_q <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            data_m_q <= data_m_d;
        end
    end

    assign dataM = data_m_q;
endmodule
